// File: rtl/eh2_lsu_clkctl_if.sv
// eh2_lsu_clkctl_if: activity inputs and clock-enable outputs of the LSU clock-enable controller
interface eh2_lsu_clkctl_if #(
  parameter int NUM_STAGES = 5,
  parameter int NUM_CHAN = 2
);
  logic                  clk_override;
  logic [NUM_STAGES:0]   stage_valid;
  logic [NUM_STAGES-1:0] stage_extra_en;
  logic [NUM_CHAN-1:0]   chan_req;
  logic [NUM_CHAN-1:0]   chan_busy;
  logic [NUM_CHAN-1:0]   force_halt;
  logic                  bus_clk_en;
  logic [NUM_CHAN-1:0]   lr_vld;
  logic [NUM_STAGES-1:0] c1_clken;
  logic [NUM_STAGES-1:0] c2_clken;
  logic [NUM_CHAN-1:0]   chan_clken;
  logic [NUM_CHAN-1:0]   chan_bus_clken;
  logic                  free_clken;
  logic [1:0]            free_state;
  logic [15:0]           gated_cnt;
  modport master (
    output clk_override, stage_valid, stage_extra_en, chan_req, chan_busy, force_halt, bus_clk_en, lr_vld,
    input  c1_clken, c2_clken, chan_clken, chan_bus_clken, free_clken, free_state, gated_cnt
  );
  modport slave (
    input  clk_override, stage_valid, stage_extra_en, chan_req, chan_busy, force_halt, bus_clk_en, lr_vld,
    output c1_clken, c2_clken, chan_clken, chan_bus_clken, free_clken, free_state, gated_cnt
  );
endinterface

// File: rtl/eh2_lsu_clkctl.sv
// eh2_lsu_clkctl: LSU clock-enable controller for pipe stages, bus channels and the free-running domain
module eh2_lsu_clkctl #(
  parameter int NUM_STAGES = 5,
  parameter int NUM_CHAN = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W = 4
) (
  input logic clk,
  input logic rst,
  eh2_lsu_clkctl_if.slave io
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
  localparam logic [CNT_W-1:0] HOLD = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_t state, state_nxt;
  logic [NUM_STAGES-1:0] c1_q, c1, ovr_s;
  logic [NUM_CHAN-1:0] act, hold_nz, chan_en;
  logic [CNT_W-1:0] hold_cnt [NUM_CHAN];
  logic [CNT_W-1:0] drain_cnt, drain_nxt;
  logic [15:0] gated_cnt;
  logic any_act, free_en;
  assign ovr_s = {NUM_STAGES{io.clk_override}};
  // each stage enable also follows the previous stage's enable one cycle later
  assign c1 = io.stage_valid[NUM_STAGES-1:0] | io.stage_extra_en | {c1_q[NUM_STAGES-2:0], 1'b0} | ovr_s;
  assign io.c1_clken = c1;
  assign io.c2_clken = c1 | c1_q | ovr_s;
  assign act = io.chan_req | io.chan_busy | io.force_halt;
  for (genvar c = 0; c < NUM_CHAN; c++) begin : g_hold
    assign hold_nz[c] = |hold_cnt[c];
  end
  assign chan_en = act | hold_nz | {NUM_CHAN{io.clk_override}};
  assign io.chan_clken = chan_en;
  assign io.chan_bus_clken = chan_en & {NUM_CHAN{io.bus_clk_en}};
  assign any_act = |io.stage_valid | |io.lr_vld | |io.chan_busy | |io.force_halt;
  assign free_en = (state != IDLE) | any_act | io.clk_override;
  assign io.free_clken = free_en;
  assign io.free_state = state;
  assign io.gated_cnt = gated_cnt;
  always_comb begin
    state_nxt = IDLE;
    drain_nxt = drain_cnt;
    case (state)
      IDLE: state_nxt = any_act ? RUN : IDLE;
      RUN: begin
        state_nxt = any_act ? RUN : (HOLD_CYCLES == 0) ? IDLE : DRAIN;
        drain_nxt = HOLD;
      end
      DRAIN: begin
        state_nxt = any_act ? RUN : (drain_cnt <= ONE) ? IDLE : DRAIN;
        drain_nxt = drain_cnt - ONE;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      drain_cnt <= '0;
      c1_q <= '0;
      gated_cnt <= '0;
    end else begin
      state <= state_nxt;
      drain_cnt <= drain_nxt;
      c1_q <= c1;
      if (!free_en && gated_cnt != 16'hFFFF) gated_cnt <= gated_cnt + 16'd1;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int c = 0; c < NUM_CHAN; c++) hold_cnt[c] <= '0;
    else for (int c = 0; c < NUM_CHAN; c++) hold_cnt[c] <= act[c] ? HOLD : hold_nz[c] ? hold_cnt[c] - ONE : hold_cnt[c];
endmodule

// File: tb/tb_eh2_lsu_clkctl.sv
// tb_eh2_lsu_clkctl: directed and randomized checks of eh2_lsu_clkctl against a cycle-history reference model
module tb_eh2_lsu_clkctl;
  localparam int NS = 5, NC = 2, HOLD = 4, DEPTH = 4096;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0, fails = 0;
  eh2_lsu_clkctl_if #(.NUM_STAGES(NS), .NUM_CHAN(NC)) io();
  eh2_lsu_clkctl #(.NUM_STAGES(NS), .NUM_CHAN(NC), .HOLD_CYCLES(HOLD), .CNT_W(4)) dut (.clk(clk), .rst(rst), .io(io));
  always #5 clk = ~clk;
  logic [NS:0] h_sv [DEPTH];
  logic [NS-1:0] h_ex [DEPTH];
  logic h_ovr [DEPTH];
  logic [NC-1:0] h_act [DEPTH];
  logic h_any [DEPTH];
  int n = 0, base = 0, last_any = -1000;
  logic [15:0] gcnt = 16'd0;
  logic [NS-1:0] exp_c1, exp_c2;
  logic [NC-1:0] exp_ch, exp_cb;
  logic exp_free;
  logic [1:0] exp_st;
  // a stage enable at cycle m is any entry into stage i-d at cycle m-d, or override then
  function automatic logic c1_at(int m, int i);
    logic r;
    r = 1'b0;
    for (int d = 0; d <= i; d++)
      if (m - d >= base) r = r | h_sv[m-d][i-d] | h_ex[m-d][i-d] | h_ovr[m-d];
    return r;
  endfunction
  task automatic clr_in();
    io.clk_override = 1'b0;
    io.stage_valid = '0;
    io.stage_extra_en = '0;
    io.chan_req = '0;
    io.chan_busy = '0;
    io.force_halt = '0;
    io.bus_clk_en = 1'b1;
    io.lr_vld = '0;
  endtask
  task automatic model_clear();
    base = n;
    gcnt = 16'd0;
    last_any = -1000;
  endtask
  task automatic model_eval();
    h_sv[n] = io.stage_valid;
    h_ex[n] = io.stage_extra_en;
    h_ovr[n] = io.clk_override;
    h_act[n] = io.chan_req | io.chan_busy | io.force_halt;
    h_any[n] = |io.stage_valid | |io.lr_vld | |io.chan_busy | |io.force_halt;
    for (int i = 0; i < NS; i++) begin
      exp_c1[i] = c1_at(n, i);
      exp_c2[i] = exp_c1[i] | c1_at(n - 1, i) | h_ovr[n];
    end
    for (int c = 0; c < NC; c++) begin
      exp_ch[c] = h_ovr[n];
      for (int k = 0; k <= HOLD; k++) if (n - k >= base) exp_ch[c] = exp_ch[c] | h_act[n-k][c];
    end
    exp_cb = exp_ch & {NC{io.bus_clk_en}};
    if (last_any < base) exp_st = 2'd0;
    else if (n - last_any == 1) exp_st = 2'd1;
    else if (n - last_any <= HOLD + 1) exp_st = 2'd2;
    else exp_st = 2'd0;
    exp_free = (exp_st != 2'd0) | h_any[n] | h_ovr[n];
  endtask
  task automatic tick();
    model_eval();
    if (rst) begin
      gcnt = 16'd0;
      last_any = -1000;
    end else begin
      if (!exp_free && gcnt != 16'hFFFF) gcnt = gcnt + 16'd1;
      if (h_any[n]) last_any = n;
    end
    @(posedge clk);
    #1;
    n++;
    if (rst) base = n;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    clr_in();
    model_clear();
    #1 model_eval();
    checks++; if (io.c1_clken !== exp_c1 || io.c2_clken !== exp_c2) begin fails++; $display("FAIL reset_stage got=%b/%b exp=%b/%b", io.c1_clken, io.c2_clken, exp_c1, exp_c2); end
    checks++; if (io.chan_clken !== exp_ch || io.free_clken !== exp_free) begin fails++; $display("FAIL reset_chan_free got=%b/%b exp=%b/%b", io.chan_clken, io.free_clken, exp_ch, exp_free); end
    tick();
    tick();
    rst = 1'b0;
    for (int t = 0; t < 10; t++) begin
      #1 model_eval();
      checks++; if (io.c1_clken !== exp_c1 || io.c2_clken !== exp_c2 || io.chan_bus_clken !== exp_cb) begin fails++; $display("FAIL idle_enables cyc=%0d got=%b/%b/%b exp=%b/%b/%b", n, io.c1_clken, io.c2_clken, io.chan_bus_clken, exp_c1, exp_c2, exp_cb); end
      checks++; if (io.free_state !== exp_st || io.gated_cnt !== gcnt) begin fails++; $display("FAIL idle_state cyc=%0d got=%0d/%0d exp=%0d/%0d", n, io.free_state, io.gated_cnt, exp_st, gcnt); end
      tick();
    end
    #1;
    checks++; if (io.gated_cnt !== 16'd10) begin fails++; $display("FAIL gated_after_10 got=%0d exp=10", io.gated_cnt); end
  endtask
  task automatic test_stage_walk();
    for (int t = 0; t < NS + 2; t++) begin
      clr_in();
      io.stage_valid[0] = (t == 0);
      #1 model_eval();
      checks++; if (io.c1_clken !== exp_c1) begin fails++; $display("FAIL walk_c1 t=%0d got=%b exp=%b", t, io.c1_clken, exp_c1); end
      checks++; if (io.c2_clken !== exp_c2) begin fails++; $display("FAIL walk_c2 t=%0d got=%b exp=%b", t, io.c2_clken, exp_c2); end
      tick();
    end
  endtask
  task automatic test_chan_hold();
    for (int t = 0; t < HOLD + 4; t++) begin
      clr_in();
      io.chan_req[1] = (t == 0);
      io.bus_clk_en = (t % 2 == 0);
      #1 model_eval();
      checks++; if (io.chan_clken !== exp_ch) begin fails++; $display("FAIL chan_clken t=%0d got=%b exp=%b", t, io.chan_clken, exp_ch); end
      checks++; if (io.chan_bus_clken !== exp_cb) begin fails++; $display("FAIL chan_bus_clken t=%0d got=%b exp=%b", t, io.chan_bus_clken, exp_cb); end
      tick();
    end
  endtask
  task automatic test_drain();
    for (int t = 0; t < 22; t++) begin
      clr_in();
      io.lr_vld[0] = (t == 0 || t == 8 || t == 13);
      #1 model_eval();
      checks++; if (io.free_state !== exp_st) begin fails++; $display("FAIL drain_state t=%0d got=%0d exp=%0d", t, io.free_state, exp_st); end
      checks++; if (io.free_clken !== exp_free || io.gated_cnt !== gcnt) begin fails++; $display("FAIL drain_free t=%0d got=%b/%0d exp=%b/%0d", t, io.free_clken, io.gated_cnt, exp_free, gcnt); end
      tick();
    end
  endtask
  task automatic test_override();
    for (int t = 0; t < 12; t++) begin
      clr_in();
      io.clk_override = (t < 6);
      #1 model_eval();
      checks++; if (io.c1_clken !== exp_c1 || io.c2_clken !== exp_c2) begin fails++; $display("FAIL ovr_stage t=%0d got=%b/%b exp=%b/%b", t, io.c1_clken, io.c2_clken, exp_c1, exp_c2); end
      checks++; if (io.chan_clken !== exp_ch || io.chan_bus_clken !== exp_cb || io.free_clken !== exp_free) begin fails++; $display("FAIL ovr_chan_free t=%0d got=%b/%b/%b exp=%b/%b/%b", t, io.chan_clken, io.chan_bus_clken, io.free_clken, exp_ch, exp_cb, exp_free); end
      checks++; if (io.free_state !== exp_st || io.gated_cnt !== gcnt) begin fails++; $display("FAIL ovr_state t=%0d got=%0d/%0d exp=%0d/%0d", t, io.free_state, io.gated_cnt, exp_st, gcnt); end
      tick();
    end
  endtask
  task automatic test_random();
    for (int t = 0; t < 300; t++) begin
      clr_in();
      if (t % 40 < 28) begin
        io.stage_valid = (NS+1)'($urandom & $urandom & $urandom);
        io.stage_extra_en = NS'($urandom & $urandom & $urandom);
        io.chan_req = NC'($urandom & $urandom);
        io.chan_busy = NC'($urandom & $urandom & $urandom);
        io.force_halt = NC'($urandom & $urandom & $urandom & $urandom);
        io.lr_vld = NC'($urandom & $urandom & $urandom);
        io.clk_override = ($urandom_range(0, 15) == 0);
      end
      io.bus_clk_en = 1'($urandom);
      #1 model_eval();
      checks++; if (io.c1_clken !== exp_c1 || io.c2_clken !== exp_c2) begin fails++; $display("FAIL rnd_stage t=%0d got=%b/%b exp=%b/%b", t, io.c1_clken, io.c2_clken, exp_c1, exp_c2); end
      checks++; if (io.chan_clken !== exp_ch || io.chan_bus_clken !== exp_cb) begin fails++; $display("FAIL rnd_chan t=%0d got=%b/%b exp=%b/%b", t, io.chan_clken, io.chan_bus_clken, exp_ch, exp_cb); end
      checks++; if (io.free_clken !== exp_free || io.free_state !== exp_st || io.gated_cnt !== gcnt) begin fails++; $display("FAIL rnd_free t=%0d got=%b/%0d/%0d exp=%b/%0d/%0d", t, io.free_clken, io.free_state, io.gated_cnt, exp_free, exp_st, gcnt); end
      tick();
    end
  endtask
  task automatic test_reset_mid();
    clr_in();
    io.chan_req[0] = 1'b1;
    io.lr_vld[0] = 1'b1;
    tick();
    clr_in();
    tick();
    #1 model_eval();
    checks++; if (io.free_state !== exp_st) begin fails++; $display("FAIL pre_reset_state got=%0d exp=%0d", io.free_state, exp_st); end
    rst = 1'b1;
    model_clear();
    #1 model_eval();
    checks++; if (io.chan_clken !== exp_ch || io.c1_clken !== exp_c1 || io.c2_clken !== exp_c2) begin fails++; $display("FAIL mid_reset_en got=%b/%b/%b exp=%b/%b/%b", io.chan_clken, io.c1_clken, io.c2_clken, exp_ch, exp_c1, exp_c2); end
    checks++; if (io.free_state !== exp_st || io.free_clken !== exp_free || io.gated_cnt !== gcnt) begin fails++; $display("FAIL mid_reset_state got=%0d/%b/%0d exp=%0d/%b/%0d", io.free_state, io.free_clken, io.gated_cnt, exp_st, exp_free, gcnt); end
    tick();
    rst = 1'b0;
    for (int t = 0; t < 4; t++) begin
      #1 model_eval();
      checks++; if (io.chan_clken !== exp_ch || io.free_state !== exp_st || io.gated_cnt !== gcnt) begin fails++; $display("FAIL post_reset t=%0d got=%b/%0d/%0d exp=%b/%0d/%0d", t, io.chan_clken, io.free_state, io.gated_cnt, exp_ch, exp_st, gcnt); end
      tick();
    end
  endtask
  initial begin
    clr_in();
    @(posedge clk);
    #1;
    test_reset();
    test_stage_walk();
    test_chan_hold();
    test_drain();
    test_override();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end
endmodule
